// File: rtl/div_seq_pkg.sv
// Shared types and sizing for the divider step sequencer.
// The optional SEQ_LOOP_EN build adds continuous looping of the step table.
package div_seq_pkg;

  localparam int STEPS   = 8;
  localparam int LIMIT_W = 21;
  localparam int DUR_W   = 16;
  localparam int AW      = $clog2(STEPS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} seq_state_t;

  typedef struct packed {
    logic [LIMIT_W-1:0] limit;
    logic [DUR_W-1:0]   dur;
  } step_t;

  // Countdown preload: a step programmed with duration 0 still plays for one cycle.
  function automatic logic [DUR_W-1:0] dur_preload(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? '0 : dur - DUR_W'(1);
  endfunction

  // Index of the final step to play; oversize requests clamp to the table depth.
  function automatic logic [AW-1:0] last_index(input logic [AW:0] num);
    logic [AW:0] n;
    n = (num > (AW+1)'(STEPS)) ? (AW+1)'(STEPS) : num;
    n = n - (AW+1)'(1);
    return n[AW-1:0];
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Control/table bus between a controller (master) and the step sequencer (slave).
// With SEQ_LOOP_EN defined the bus carries an extra loop request.
interface div_seq_if;
  import div_seq_pkg::*;

  logic               step_we;
  logic [AW-1:0]      step_addr;
  logic [LIMIT_W-1:0] step_limit;
  logic [DUR_W-1:0]   step_dur;
  logic [AW:0]        num_steps;
  logic               start;
  logic               abort;
`ifdef SEQ_LOOP_EN
  logic               loop;
`endif
  logic [LIMIT_W-1:0] limit;
  logic               div_en;
  logic               busy;
  logic               done;
  logic [AW-1:0]      cur_step;

  modport master (
`ifdef SEQ_LOOP_EN
    output loop,
`endif
    output step_we, step_addr, step_limit, step_dur, num_steps, start, abort,
    input  limit, div_en, busy, done, cur_step
  );

  modport slave (
`ifdef SEQ_LOOP_EN
    input  loop,
`endif
    input  step_we, step_addr, step_limit, step_dur, num_steps, start, abort,
    output limit, div_en, busy, done, cur_step
  );

endinterface

// File: rtl/div_seq_table.sv
// Step table: register file with a synchronous gated write port and an asynchronous read port.
module div_seq_table
  import div_seq_pkg::*;
#(
  parameter int DEPTH  = STEPS,
  parameter int ADDR_W = AW
)(
  input  logic              clk_20k,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  step_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output step_t             rdata
);

  step_t mem [DEPTH];

  // Contents are deliberately left out of reset; the controller rewrites the table as needed.
  always_ff @(posedge clk_20k) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/div_seq_ctrl.sv
// Plays a programmed table of {limit, duration} steps into a clock divider's limit input.
// Define SEQ_LOOP_EN to let the loop request wrap the last step back to step 0.
module div_seq_ctrl
  import div_seq_pkg::*;
(
  input logic      clk_20k,
  input logic      reset,
  div_seq_if.slave bus
);

  seq_state_t         state, state_nxt;
  logic [AW-1:0]      cur_step, cur_step_nxt;
  logic [AW-1:0]      last_step, last_step_nxt;
  logic [AW-1:0]      rd_addr, next_idx;
  logic [DUR_W-1:0]   dur_cnt, dur_cnt_nxt;
  logic [LIMIT_W-1:0] limit_q, limit_nxt;
  logic               loop_en;
  logic               tbl_we;
  logic               run_o;
  logic               done_o;
  step_t              rd_step;
  step_t              wr_step;

`ifdef SEQ_LOOP_EN
  assign loop_en = bus.loop;
`else
  assign loop_en = 1'b0;
`endif

  // Table writes are only accepted while nothing is playing.
  assign tbl_we   = bus.step_we && (state != S_RUN);
  assign wr_step  = {bus.step_limit, bus.step_dur};
  assign next_idx = cur_step + AW'(1);

  div_seq_table #(
    .DEPTH  (STEPS),
    .ADDR_W (AW)
  ) u_table (
    .clk_20k (clk_20k),
    .we      (tbl_we),
    .waddr   (bus.step_addr),
    .wdata   (wr_step),
    .raddr   (rd_addr),
    .rdata   (rd_step)
  );

  always_ff @(posedge clk_20k or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_step  <= '0;
      last_step <= '0;
      dur_cnt   <= '0;
      limit_q   <= '0;
    end else begin
      state     <= state_nxt;
      cur_step  <= cur_step_nxt;
      last_step <= last_step_nxt;
      dur_cnt   <= dur_cnt_nxt;
      limit_q   <= limit_nxt;
    end
  end

  // Next step is loaded on the same edge the current one expires, so steps abut without a gap.
  always_comb begin
    state_nxt     = state;
    cur_step_nxt  = cur_step;
    last_step_nxt = last_step;
    dur_cnt_nxt   = dur_cnt;
    limit_nxt     = limit_q;
    rd_addr       = next_idx;
    unique case (state)
      S_IDLE: begin
        rd_addr = '0;
        if (bus.start && (bus.num_steps != '0)) begin
          state_nxt     = S_RUN;
          cur_step_nxt  = '0;
          last_step_nxt = last_index(bus.num_steps);
          dur_cnt_nxt   = dur_preload(rd_step.dur);
          limit_nxt     = rd_step.limit;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else if (dur_cnt != '0) begin
          dur_cnt_nxt = dur_cnt - DUR_W'(1);
        end else if (cur_step != last_step) begin
          cur_step_nxt = next_idx;
          dur_cnt_nxt  = dur_preload(rd_step.dur);
          limit_nxt    = rd_step.limit;
        end else if (loop_en) begin
          rd_addr      = '0;
          cur_step_nxt = '0;
          dur_cnt_nxt  = dur_preload(rd_step.dur);
          limit_nxt    = rd_step.limit;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    run_o  = 1'b0;
    done_o = 1'b0;
    unique case (state)
      S_RUN:   run_o  = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.limit    = limit_q;
  assign bus.div_en   = run_o;
  assign bus.busy     = run_o;
  assign bus.done     = done_o;
  assign bus.cur_step = cur_step;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: random step tables checked against a per-cycle list model of the step table.
// Build with SEQ_LOOP_EN defined to also exercise looping.
module tb_div_seq_ctrl;
  import div_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [LIMIT_W-1:0] m_lim [STEPS];
  logic [DUR_W-1:0]   m_dur [STEPS];
  logic [LIMIT_W-1:0] exp_lim [$];
  logic [AW-1:0]      exp_idx [$];

  div_seq_if bus();

  div_seq_ctrl dut (
    .clk_20k (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_inputs();
    bus.step_we    = 1'b0;
    bus.step_addr  = '0;
    bus.step_limit = '0;
    bus.step_dur   = '0;
    bus.num_steps  = '0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
`ifdef SEQ_LOOP_EN
    bus.loop       = 1'b0;
`endif
  endtask

  task automatic write_step(input int addr, input logic [LIMIT_W-1:0] lim, input logic [DUR_W-1:0] dur);
    @(negedge clk);
    bus.step_we    = 1'b1;
    bus.step_addr  = AW'(addr);
    bus.step_limit = lim;
    bus.step_dur   = dur;
    m_lim[addr]    = lim;
    m_dur[addr]    = dur;
    @(negedge clk);
    bus.step_we    = 1'b0;
  endtask

  task automatic write_basic();
    write_step(0, 21'd9, 16'd5);
    write_step(1, 21'd99, 16'd3);
    write_step(2, 21'd4, 16'd1);
  endtask

  // Expected output stream: each step repeated max(dur,1) times, over min(n,STEPS) steps.
  task automatic build_expected(input int n);
    int cnt;
    cnt = (n > STEPS) ? STEPS : n;
    exp_lim.delete();
    exp_idx.delete();
    for (int i = 0; i < cnt; i++) begin
      int d;
      d = (m_dur[i] == '0) ? 1 : int'(m_dur[i]);
      for (int k = 0; k < d; k++) begin
        exp_lim.push_back(m_lim[i]);
        exp_idx.push_back(AW'(i));
      end
    end
  endtask

  task automatic play_sequence(input int n, input string tag);
    logic [LIMIT_W-1:0] last;
    build_expected(n);
    last = exp_lim[exp_lim.size()-1];
    @(negedge clk);
    bus.num_steps = (AW+1)'(n);
    bus.start     = 1'b1;
    foreach (exp_lim[k]) begin
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if ({bus.limit, bus.cur_step, bus.busy, bus.div_en, bus.done} !== {exp_lim[k], exp_idx[k], 3'b110}) begin
        errors++;
        $display("[TB] FAIL %s run cycle %0d: got limit=%0d step=%0d busy=%b en=%b done=%b, want limit=%0d step=%0d busy=1 en=1 done=0",
                 tag, k+1, bus.limit, bus.cur_step, bus.busy, bus.div_en, bus.done, exp_lim[k], exp_idx[k]);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.limit, bus.busy, bus.div_en, bus.done} !== {last, 3'b001}) begin
      errors++;
      $display("[TB] FAIL %s done cycle: got limit=%0d busy=%b en=%b done=%b, want limit=%0d busy=0 en=0 done=1",
               tag, bus.limit, bus.busy, bus.div_en, bus.done, last);
    end
    @(negedge clk);
    checks++;
    if ({bus.limit, bus.busy, bus.div_en, bus.done} !== {last, 3'b000}) begin
      errors++;
      $display("[TB] FAIL %s idle after done: got limit=%0d busy=%b en=%b done=%b, want limit=%0d busy=0 en=0 done=0",
               tag, bus.limit, bus.busy, bus.div_en, bus.done, last);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.limit, bus.cur_step, bus.busy, bus.div_en, bus.done} !== '0) begin
      errors++;
      $display("[TB] FAIL reset state: got limit=%0d step=%0d busy=%b en=%b done=%b, want all 0",
               bus.limit, bus.cur_step, bus.busy, bus.div_en, bus.done);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    write_basic();
    play_sequence(3, "basic");
  endtask

  task automatic test_num_steps();
    @(negedge clk);
    bus.num_steps = '0;
    bus.start     = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.div_en, bus.done} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL num_steps=0 cycle %0d: got busy=%b en=%b done=%b, want 0 0 0",
                 c, bus.busy, bus.div_en, bus.done);
      end
    end
    bus.start = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      write_step(i, LIMIT_W'($urandom), (i == 3) ? 16'd0 : DUR_W'($urandom_range(0, 3)));
    end
    play_sequence(12, "clamp12");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < STEPS; i++) begin
        write_step(i, LIMIT_W'($urandom), DUR_W'($urandom_range(0, 5)));
      end
      play_sequence($urandom_range(1, 15), "random");
    end
  endtask

  task automatic test_abort();
    write_basic();
    @(negedge clk);
    bus.num_steps = 4'd3;
    bus.start     = 1'b1;
    repeat (7) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if ({bus.limit, bus.busy, bus.div_en, bus.done} !== {21'd99, 3'b000}) begin
      errors++;
      $display("[TB] FAIL abort mid step1: got limit=%0d busy=%b en=%b done=%b, want limit=99 busy=0 en=0 done=0",
               bus.limit, bus.busy, bus.div_en, bus.done);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL after abort cycle %0d: got busy=%b done=%b, want 0 0", c, bus.busy, bus.done);
      end
    end
    // Abort coinciding with the final step's expiry must suppress done.
    @(negedge clk);
    bus.start = 1'b1;
    repeat (9) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if ({bus.limit, bus.busy, bus.div_en, bus.done} !== {21'd4, 3'b000}) begin
      errors++;
      $display("[TB] FAIL abort on last expiry: got limit=%0d busy=%b en=%b done=%b, want limit=4 busy=0 en=0 done=0",
               bus.limit, bus.busy, bus.div_en, bus.done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL done after last-step abort cycle %0d: got done=%b, want 0", c, bus.done);
      end
    end
  endtask

  task automatic test_write_during_run();
    bit seen;
    write_basic();
    @(negedge clk);
    bus.num_steps = 4'd3;
    bus.start     = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.step_we    = 1'b1;
    bus.step_addr  = '0;
    bus.step_limit = 21'd777;
    bus.step_dur   = 16'd5;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      bus.step_we = 1'b0;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL write-during-run completion: got no done within 40 cycles, want done");
    end
    play_sequence(3, "after dropped write");
    write_step(0, 21'd777, 16'd5);
    play_sequence(3, "after idle write");
  endtask

  task automatic test_async_reset();
    write_basic();
    @(negedge clk);
    bus.num_steps = 4'd3;
    bus.start     = 1'b1;
    repeat (7) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.limit, bus.cur_step, bus.busy, bus.div_en, bus.done} !== '0) begin
      errors++;
      $display("[TB] FAIL async reset mid-step: got limit=%0d step=%0d busy=%b en=%b done=%b, want all 0",
               bus.limit, bus.cur_step, bus.busy, bus.div_en, bus.done);
    end
    @(negedge clk);
    reset = 1'b0;
    write_basic();
    play_sequence(3, "replay after reset");
  endtask

  task automatic test_back_to_back();
    write_basic();
    build_expected(3);
    @(negedge clk);
    bus.num_steps = 4'd3;
    bus.start     = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      foreach (exp_lim[k]) begin
        @(negedge clk);
        if (pass == 1) bus.start = 1'b0;
        checks++;
        if ({bus.limit, bus.cur_step, bus.busy, bus.div_en, bus.done} !== {exp_lim[k], exp_idx[k], 3'b110}) begin
          errors++;
          $display("[TB] FAIL back-to-back pass %0d cycle %0d: got limit=%0d step=%0d busy=%b done=%b, want limit=%0d step=%0d busy=1 done=0",
                   pass, k+1, bus.limit, bus.cur_step, bus.busy, bus.done, exp_lim[k], exp_idx[k]);
        end
      end
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL back-to-back pass %0d done: got busy=%b done=%b, want 0 1", pass, bus.busy, bus.done);
      end
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL back-to-back pass %0d idle gap: got busy=%b done=%b, want 0 0", pass, bus.busy, bus.done);
      end
    end
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_loop();
    write_step(0, 21'd3, 16'd2);
    write_step(1, 21'd5, 16'd2);
    build_expected(2);
    @(negedge clk);
    bus.loop      = 1'b1;
    bus.num_steps = 4'd2;
    bus.start     = 1'b1;
    for (int pass = 0; pass < 3; pass++) begin
      foreach (exp_lim[k]) begin
        @(negedge clk);
        bus.start = 1'b0;
        if (pass == 2 && k == 0) bus.loop = 1'b0;
        checks++;
        if ({bus.limit, bus.cur_step, bus.busy, bus.done} !== {exp_lim[k], exp_idx[k], 2'b10}) begin
          errors++;
          $display("[TB] FAIL loop pass %0d cycle %0d: got limit=%0d step=%0d busy=%b done=%b, want limit=%0d step=%0d busy=1 done=0",
                   pass, k+1, bus.limit, bus.cur_step, bus.busy, bus.done, exp_lim[k], exp_idx[k]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.limit, bus.busy, bus.done} !== {21'd5, 2'b01}) begin
      errors++;
      $display("[TB] FAIL loop exit done: got limit=%0d busy=%b done=%b, want limit=5 busy=0 done=1",
               bus.limit, bus.busy, bus.done);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    $display("[TB] div_seq_ctrl bench starting");
    test_reset();
    test_basic();
    test_num_steps();
    test_random();
    test_abort();
    test_write_during_run();
    test_async_reset();
    test_back_to_back();
`ifdef SEQ_LOOP_EN
    test_loop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
